// File: rtl/vend_txn_ctrl_pkg.sv
// Shared types and helpers for the vending transaction sequencer:
// FSM state encoding, coin denominations and the price-table lookup.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam logic [3:0] COIN_1  = 4'd1;
    localparam logic [3:0] COIN_2  = 4'd2;
    localparam logic [3:0] COIN_5  = 4'd5;
    localparam logic [3:0] COIN_10 = 4'd10;

    // item0 lives in bits [7:0], item3 in bits [31:24]
    localparam logic [31:0] PRICES_DEFAULT = 32'h1E19140F;

    function automatic logic [7:0] price_of(input logic [1:0]  idx,
                                            input logic [31:0] prices = PRICES_DEFAULT);
        return prices[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic coin_legal(input logic [3:0] value);
        return (value == COIN_1) || (value == COIN_2) ||
               (value == COIN_5) || (value == COIN_10);
    endfunction

endpackage

// File: rtl/vend_txn_ctrl_if.sv
// Handshake bundle between the sequencer and the coin acceptor, item buttons,
// dispense mechanism and refund hopper.
interface vend_txn_ctrl_if #(
    parameter int unsigned CREDIT_W = 8
);
    logic                coin_in;
    logic [3:0]          coin_value;
    logic [3:0]          push;
    logic [3:0]          sold_out;
    logic                cancel;
    logic                dispense_ack;
    logic                refund_ready;
    logic [3:0]          dispense;
    logic [3:0]          refund;
    logic                refund_valid;
    logic [CREDIT_W-1:0] credit;
    logic                coin_reject;
    logic                busy;

    // The sequencer itself
    modport slave (
        input  coin_in, coin_value, push, sold_out, cancel, dispense_ack, refund_ready,
        output dispense, refund, refund_valid, credit, coin_reject, busy
    );

    // The surrounding mechanisms / environment
    modport master (
        output coin_in, coin_value, push, sold_out, cancel, dispense_ack, refund_ready,
        input  dispense, refund, refund_valid, credit, coin_reject, busy
    );
endinterface

// File: rtl/vend_change_sel.sv
// Greedy change selector: picks the largest coin (10/5/2/1) not exceeding the
// remaining credit, or 0 when nothing is owed.
module vend_change_sel
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] credit_i,
    output logic [3:0]          coin_o
);

    always_comb begin
        if (credit_i >= CREDIT_W'(COIN_10)) begin
            coin_o = COIN_10;
        end else if (credit_i >= CREDIT_W'(COIN_5)) begin
            coin_o = COIN_5;
        end else if (credit_i >= CREDIT_W'(COIN_2)) begin
            coin_o = COIN_2;
        end else if (credit_i >= CREDIT_W'(COIN_1)) begin
            coin_o = COIN_1;
        end else begin
            coin_o = 4'd0;
        end
    end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: accumulates coin credit, matches button
// presses against the price table, drives dispense and pays change greedily.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned         CREDIT_W   = 8,
    parameter logic [CREDIT_W-1:0] MAX_CREDIT = CREDIT_W'(99),
    parameter logic [31:0]         PRICES     = 32'h1E19140F,
    parameter logic [15:0]         TIMEOUT    = 16'd50000
) (
    input  logic            clk,
    input  logic            rst_n,
    vend_txn_ctrl_if.slave  bus
);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [15:0]         timer_q, timer_d;
    logic [3:0]          dispense_q, dispense_d;
    logic [3:0]          refund_q, refund_d;
    logic                refund_valid_q, refund_valid_d;
    logic                coin_reject_q, coin_reject_d;
    logic                busy_q, busy_d;

    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic                coin_accept;
    logic [1:0]          push_idx;
    logic [CREDIT_W-1:0] item_price;
    logic                push_ok;
    logic                xfer;
    logic [CREDIT_W-1:0] credit_after;
    logic [CREDIT_W-1:0] sel_credit;
    logic [3:0]          sel_coin;

    // One extra bit on the sum so a near-full credit plus a coin never wraps below MAX_CREDIT
    assign coin_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(bus.coin_value);
    assign coin_fits = coin_legal(bus.coin_value) && (coin_sum <= {1'b0, MAX_CREDIT});

    always_comb begin : pick_item
        push_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.push[i]) begin
                push_idx = 2'(i);
            end
        end
    end

    assign item_price = CREDIT_W'(price_of(push_idx, PRICES));
    assign push_ok    = (|bus.push) && !bus.sold_out[push_idx] && (credit_q >= item_price);

    // After a transfer the next coin is chosen from the post-payout credit, so
    // back-to-back refunds need no idle cycle between them.
    assign xfer         = refund_valid_q && bus.refund_ready;
    assign credit_after = credit_q - CREDIT_W'(refund_q);
    assign sel_credit   = xfer ? credit_after : credit_q;

    vend_change_sel #(
        .CREDIT_W (CREDIT_W)
    ) u_change_sel (
        .credit_i (sel_credit),
        .coin_o   (sel_coin)
    );

    always_comb begin : fsm_next
        // NOTE: every _d gets its hold value first so no branch can infer a latch.
        state_d        = state_q;
        credit_d       = credit_q;
        timer_d        = timer_q;
        dispense_d     = dispense_q;
        refund_d       = refund_q;
        refund_valid_d = refund_valid_q;
        coin_accept    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.coin_in && coin_fits) begin
                    coin_accept = 1'b1;
                    credit_d    = coin_sum[CREDIT_W-1:0];
                    timer_d     = '0;
                    state_d     = CREDIT;
                end
            end
            CREDIT: begin
                if (bus.cancel || (timer_q >= TIMEOUT)) begin
                    state_d = CHANGE;
                end else if (bus.coin_in && coin_fits) begin
                    coin_accept = 1'b1;
                    credit_d    = coin_sum[CREDIT_W-1:0];
                    timer_d     = '0;
                end else if (!bus.coin_in && push_ok) begin
                    state_d    = VEND;
                    dispense_d = 4'b0001 << push_idx;
                    credit_d   = credit_q - item_price;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            VEND: begin
                if (bus.dispense_ack) begin
                    dispense_d = '0;
                    state_d    = (credit_q != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (xfer) begin
                    credit_d = credit_after;
                    if (credit_after == '0) begin
                        state_d        = IDLE;
                        refund_valid_d = 1'b0;
                        refund_d       = '0;
                    end else begin
                        refund_d = sel_coin;
                    end
                end else if (!refund_valid_q) begin
                    if (credit_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        refund_d       = sel_coin;
                        refund_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        coin_reject_d = bus.coin_in && !coin_accept;
        busy_d        = (state_d == VEND) || (state_d == CHANGE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            timer_q        <= '0;
            dispense_q     <= '0;
            refund_q       <= '0;
            refund_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the same pre-edge values.
            state_q        <= state_d;
            credit_q       <= credit_d;
            timer_q        <= timer_d;
            dispense_q     <= dispense_d;
            refund_q       <= refund_d;
            refund_valid_q <= refund_valid_d;
            coin_reject_q  <= coin_reject_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.dispense     = dispense_q;
    assign bus.refund       = refund_q;
    assign bus.refund_valid = refund_valid_q;
    assign bus.credit       = credit_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Bench for vend_txn_ctrl: directed vector table, hand-written multi-cycle
// sequences, and random traffic against a transaction-level credit model.
module tb_vend_txn_ctrl;

    typedef struct packed {
        logic [3:0] dispense;
        logic [3:0] refund;
        logic       rv;
        logic [7:0] credit;
        logic       reject;
        logic       busy;
    } outs_t;

    typedef struct {
        logic       coin_in;
        logic [3:0] coin_value;
        logic [3:0] push;
        logic [3:0] sold_out;
        logic       cancel;
        logic       ack;
        logic       ready;
        outs_t      exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    vend_txn_ctrl_if #(.CREDIT_W(8)) bus ();
    vend_txn_ctrl_if #(.CREDIT_W(8)) bus_to ();

    vend_txn_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vend_txn_ctrl #(
        .TIMEOUT (16'd8)
    ) u_dut_to (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic outs_t get_outs();
        return '{bus.dispense, bus.refund, bus.refund_valid, bus.credit, bus.coin_reject, bus.busy};
    endfunction

    function automatic outs_t get_outs_to();
        return '{bus_to.dispense, bus_to.refund, bus_to.refund_valid, bus_to.credit,
                 bus_to.coin_reject, bus_to.busy};
    endfunction

    task automatic drive(input vec_t v);
        bus.coin_in      = v.coin_in;
        bus.coin_value   = v.coin_value;
        bus.push         = v.push;
        bus.sold_out     = v.sold_out;
        bus.cancel       = v.cancel;
        bus.dispense_ack = v.ack;
        bus.refund_ready = v.ready;
    endtask

    task automatic idle_inputs();
        bus.coin_in = 0; bus.coin_value = 0; bus.push = 0; bus.sold_out = 0;
        bus.cancel = 0; bus.dispense_ack = 0; bus.refund_ready = 0;
    endtask

    // ---------------- directed vector table ----------------
    vec_t vecs[$];

    task automatic add_vec(input logic ci, input logic [3:0] cv, input logic [3:0] push,
                           input logic [3:0] sold, input logic cancel, input logic ack,
                           input logic ready, input int cr, input logic [3:0] disp,
                           input logic [3:0] refund, input logic rv, input logic rej,
                           input logic busy);
        vec_t v;
        v.coin_in = ci; v.coin_value = cv; v.push = push; v.sold_out = sold;
        v.cancel = cancel; v.ack = ack; v.ready = ready;
        v.exp = '{disp, refund, rv, 8'(cr), rej, busy};
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    int PRICE [4] = '{15, 20, 25, 30};
    int m_credit;
    int m_item;
    int m_coins[$];
    bit m_chg;
    bit m_bubble;
    bit m_rv;
    bit m_rej;

    task automatic model_reset();
        m_credit = 0; m_item = -1; m_coins.delete();
        m_chg = 0; m_bubble = 0; m_rv = 0; m_rej = 0;
    endtask

    function automatic bit legal_coin(input int v);
        return (v == 1) || (v == 2) || (v == 5) || (v == 10);
    endfunction

    // Whole greedy payout list is worked out once when change starts
    task automatic start_change();
        int c;
        c = m_credit;
        m_coins.delete();
        while (c > 0) begin
            if (c >= 10)     begin m_coins.push_back(10); c -= 10; end
            else if (c >= 5) begin m_coins.push_back(5);  c -= 5;  end
            else if (c >= 2) begin m_coins.push_back(2);  c -= 2;  end
            else             begin m_coins.push_back(1);  c -= 1;  end
        end
        m_chg = 1; m_bubble = 1; m_rv = 0;
    endtask

    task automatic model_step(input bit ci, input int cv, input logic [3:0] push,
                              input logic [3:0] sold, input bit cancel, input bit ack,
                              input bit ready);
        int sel;
        m_rej = 0;
        if (m_item >= 0) begin
            m_rej = ci;
            if (ack) begin
                m_item = -1;
                if (m_credit > 0) start_change();
            end
        end else if (m_chg) begin
            m_rej = ci;
            if (m_bubble) begin
                m_bubble = 0;
                m_rv     = 1;
            end else if (m_rv && ready) begin
                m_credit -= m_coins.pop_front();
                if (m_coins.size() == 0) begin
                    m_chg = 0;
                    m_rv  = 0;
                end
            end
        end else if (m_credit > 0) begin
            if (cancel) begin
                m_rej = ci;
                start_change();
            end else if (ci) begin
                if (legal_coin(cv) && (m_credit + cv <= 99)) m_credit += cv;
                else m_rej = 1;
            end else if (push != 0) begin
                sel = 0;
                for (int k = 3; k >= 0; k--) if (push[k]) sel = k;
                if (!sold[sel] && (m_credit >= PRICE[sel])) begin
                    m_item    = sel;
                    m_credit -= PRICE[sel];
                end
            end
        end else if (ci) begin
            if (legal_coin(cv)) m_credit = cv;
            else m_rej = 1;
        end
    endtask

    function automatic outs_t model_outs();
        outs_t o;
        o.dispense = (m_item >= 0) ? 4'(1 << m_item) : 4'd0;
        o.refund   = m_rv ? 4'(m_coins[0]) : 4'd0;
        o.rv       = m_rv;
        o.credit   = 8'(m_credit);
        o.reject   = m_rej;
        o.busy     = (m_item >= 0) || m_chg;
        return o;
    endfunction

    // ---------------- refund drain with toggling ready ----------------
    int exp_q[$];

    task automatic drain(input string name);
        logic [3:0] pre_ref;
        logic       pre_rv;
        int         pre_credit;
        int         want;
        bit         ready;
        bit         done;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            ready            = k[0];
            bus.refund_ready = ready;
            pre_rv     = bus.refund_valid;
            pre_ref    = bus.refund;
            pre_credit = int'(bus.credit);
            tick();
            if (pre_rv && ready) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
                check({name, "_coin"}, 32'(pre_ref), 32'(want));
                check({name, "_dec"}, 32'(bus.credit), 32'(pre_credit - int'(pre_ref)));
            end else if (pre_rv) begin
                check({name, "_hold"}, {27'd0, bus.refund_valid, bus.refund}, {27'd0, 1'b1, pre_ref});
            end
            if (exp_q.size() == 0 && !bus.refund_valid && !bus.busy) done = 1;
        end
        bus.refund_ready = 0;
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_credit0"}, 32'(bus.credit), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] cvals [12];
        logic [3:0] sold;
        bit         ci, cancel, ack, ready;
        logic [3:0] cv, push;
        bit         early;

        cvals = '{4'd1, 4'd2, 4'd5, 4'd10, 4'd1, 4'd2, 4'd5, 4'd10, 4'd3, 4'd0, 4'd15, 4'd7};

        rst_n = 0;
        idle_inputs();
        bus_to.coin_in = 0; bus_to.coin_value = 0; bus_to.push = 0; bus_to.sold_out = 0;
        bus_to.cancel = 0; bus_to.dispense_ack = 0; bus_to.refund_ready = 0;
        tick();
        tick();
        check("reset_main", 32'(get_outs()), 32'd0);
        check("reset_to", 32'(get_outs_to()), 32'd0);
        rst_n = 1;

        // A: 10+5, buy item0 at 15, no change
        add_vec(1, 10, 0, 0, 0, 0, 0,  10, 0, 0, 0, 0, 0);
        add_vec(1,  5, 0, 0, 0, 0, 0,  15, 0, 0, 0, 0, 0);
        add_vec(0,  0, 4'b0001, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 1);
        add_vec(0,  0, 0, 0, 0, 0, 0,   0, 4'b0001, 0, 0, 0, 1);
        add_vec(0,  0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0);
        add_vec(0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // B: 25, buy item1 at 20, one 5 back
        add_vec(1, 10, 0, 0, 0, 0, 0,  10, 0, 0, 0, 0, 0);
        add_vec(1, 10, 0, 0, 0, 0, 0,  20, 0, 0, 0, 0, 0);
        add_vec(1,  5, 0, 0, 0, 0, 0,  25, 0, 0, 0, 0, 0);
        add_vec(0,  0, 4'b0010, 0, 0, 0, 0, 5, 4'b0010, 0, 0, 0, 1);
        add_vec(0,  0, 0, 0, 0, 1, 0,   5, 0, 0, 0, 0, 1);
        add_vec(0,  0, 0, 0, 0, 0, 0,   5, 0, 5, 1, 0, 1);
        add_vec(0,  0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        add_vec(0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // D: refused pushes (short credit, sold out), then lowest index wins
        add_vec(1, 10, 0, 0, 0, 0, 0,  10, 0, 0, 0, 0, 0);
        add_vec(1, 10, 0, 0, 0, 0, 0,  20, 0, 0, 0, 0, 0);
        add_vec(0,  0, 4'b0100, 0, 0, 0, 0, 20, 0, 0, 0, 0, 0);
        add_vec(1, 10, 0, 0, 0, 0, 0,  30, 0, 0, 0, 0, 0);
        add_vec(0,  0, 4'b0100, 4'b0100, 0, 0, 0, 30, 0, 0, 0, 0, 0);
        add_vec(0,  0, 4'b1100, 0, 0, 0, 0, 5, 4'b0100, 0, 0, 0, 1);
        add_vec(0,  0, 0, 0, 0, 1, 0,   5, 0, 0, 0, 0, 1);
        add_vec(0,  0, 0, 0, 0, 0, 0,   5, 0, 5, 1, 0, 1);
        add_vec(0,  0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        // C: fill to 95, overflow and illegal coins refused, 99 boundary, cancel
        for (int k = 1; k <= 9; k++) add_vec(1, 10, 0, 0, 0, 0, 0, 10 * k, 0, 0, 0, 0, 0);
        add_vec(1,  5, 0, 0, 0, 0, 0,  95, 0, 0, 0, 0, 0);
        add_vec(1, 10, 0, 0, 0, 0, 0,  95, 0, 0, 0, 1, 0);
        add_vec(1,  3, 0, 0, 0, 0, 0,  95, 0, 0, 0, 1, 0);
        add_vec(1,  2, 0, 0, 0, 0, 0,  97, 0, 0, 0, 0, 0);
        add_vec(1,  2, 0, 0, 0, 0, 0,  99, 0, 0, 0, 0, 0);
        add_vec(1,  1, 0, 0, 0, 0, 0,  99, 0, 0, 0, 1, 0);
        add_vec(0,  0, 0, 0, 1, 0, 0,  99, 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            tick();
            check($sformatf("vec%0d", i), 32'(get_outs()), 32'(vecs[i].exp));
        end
        idle_inputs();
        for (int k = 0; k < 9; k++) exp_q.push_back(10);
        exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(2);
        drain("drain99");

        // Cancel with 13: refunds 10, 2, 1 in order, each held until ready
        bus.coin_in = 1; bus.coin_value = 10; tick();
        bus.coin_value = 2; tick();
        bus.coin_value = 1; tick();
        bus.coin_in = 0;
        check("cancel_credit", 32'(bus.credit), 32'd13);
        bus.cancel = 1; tick(); bus.cancel = 0;
        exp_q.push_back(10); exp_q.push_back(2); exp_q.push_back(1);
        drain("cancel13");

        // Reset in the middle of a payout
        bus.coin_in = 1; bus.coin_value = 10; tick(); bus.coin_in = 0;
        bus.cancel = 1; tick(); bus.cancel = 0;
        tick();
        check("rst_pre_rv", 32'(bus.refund_valid), 32'd1);
        rst_n = 0; tick(); rst_n = 1;
        check("rst_mid", 32'(get_outs()), 32'd0);
        bus.coin_in = 1; bus.coin_value = 5; tick(); bus.coin_in = 0;
        check("rst_after", 32'(get_outs()), 32'({4'd0, 4'd0, 1'b0, 8'd5, 1'b0, 1'b0}));
        bus.cancel = 1; tick(); bus.cancel = 0;
        exp_q.push_back(5);
        drain("rst_drain");

        // Inactivity timeout on the short-TIMEOUT instance
        bus_to.coin_in = 1; bus_to.coin_value = 5; tick(); bus_to.coin_in = 0;
        check("to_credit", 32'(bus_to.credit), 32'd5);
        early = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus_to.refund_valid) early = 1;
        end
        check("to_early", 32'(early), 32'd0);
        for (int k = 0; k < 10 && !bus_to.refund_valid; k++) tick();
        check("to_fire", 32'(bus_to.refund_valid), 32'd1);
        check("to_coin", 32'(bus_to.refund), 32'd5);
        bus_to.refund_ready = 1; tick(); bus_to.refund_ready = 0;
        check("to_done", 32'(get_outs_to()), 32'd0);

        // Random traffic against the model, from a clean reset
        rst_n = 0; idle_inputs(); tick(); rst_n = 1;
        model_reset();
        sold = 4'($urandom);
        for (int n = 0; n < 2500; n++) begin
            if (n % 64 == 0) sold = 4'($urandom) & 4'($urandom);
            ci     = ($urandom_range(0, 3) == 0);
            cv     = cvals[$urandom_range(0, 11)];
            push   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            cancel = ($urandom_range(0, 40) == 0);
            ack    = ($urandom_range(0, 2) == 0);
            ready  = ($urandom_range(0, 1) == 1);
            bus.coin_in = ci; bus.coin_value = cv; bus.push = push; bus.sold_out = sold;
            bus.cancel = cancel; bus.dispense_ack = ack; bus.refund_ready = ready;
            model_step(ci, int'(cv), push, sold, cancel, ack, ready);
            tick();
            check($sformatf("rand%0d", n), 32'(get_outs()), 32'(model_outs()));
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
